if_prefetch_queue: RTL and testbench

//   Instruction-fetch front end that sits directly upstream of the pipelined CPU decode stage.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fifo.sv | 103 ++++++++++
 rtl/if_prefetch_queue.sv | 152 +++++++++++++++
 tb/tb_if_prefetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// DEPTH-entry circular buffer of {pc, instr} pairs with a registered head.
// Flush empties it in one cycle; head data registers keep their last value while empty.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic                   i_load_head,
  input  fetch_entry_t           i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_head_valid,
  output fetch_entry_t           o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_valid;
  fetch_entry_t  r_head;

  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_wr_next;
  logic [CW-1:0] w_count_next;
  fetch_entry_t  w_head_next;

  // Next pointers, occupancy and head; a push into an (effectively) empty queue lands straight in the head
  always_comb begin
    w_rd_next    = r_rd_ptr;
    w_wr_next    = r_wr_ptr;
    w_count_next = r_count;
    w_head_next  = r_head;
    if (i_flush) begin
      w_rd_next    = '0;
      w_wr_next    = '0;
      w_count_next = '0;
    end else begin
      if (i_pop) begin
        w_rd_next = r_rd_ptr + PW'(1'b1);
      end else begin
        w_rd_next = r_rd_ptr;
      end
      if (i_push) begin
        w_wr_next = r_wr_ptr + PW'(1'b1);
      end else begin
        w_wr_next = r_wr_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   w_count_next = r_count + CW'(1'b1);
        2'b01:   w_count_next = r_count - CW'(1'b1);
        default: w_count_next = r_count;
      endcase
      if (w_count_next != '0) begin
        if (i_push && (r_wr_ptr == w_rd_next)) begin
          w_head_next = i_data;
        end else begin
          w_head_next = r_mem[w_rd_next];
        end
      end else if (i_load_head) begin
        w_head_next = i_data;
      end else begin
        w_head_next = r_head;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '{pc: {XLEN{1'b0}}, instr: NOP_INSTR};
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= w_wr_next;
      r_count      <= w_count_next;
      r_head_valid <= (w_count_next != '0);
      r_head       <= w_head_next;
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = r_head_valid;
  assign o_head       = r_head;

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns the PC, drives a 1-cycle instruction memory, queues responses for decode.
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_redirect_addr;
  logic            w_slot_free;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_load_head;
  fetch_entry_t    w_resp_entry;
  logic [CW-1:0]   w_count;
  logic            w_head_valid;
  fetch_entry_t    w_head;
  logic            w_unused_redirect_lsbs;

  assign w_redirect_addr        = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
  // The in-flight request keeps a slot reserved so its response can always be pushed
  assign w_slot_free            = (w_count + CW'(r_inflight)) < CW'(DEPTH);

  // Fetch FSM: request issue and state transitions; a redirect always re-targets immediately
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        if (redirect_valid || w_slot_free) begin
          w_req = 1'b1;
        end else begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_req        = 1'b1;
          w_state_next = FETCH;
        end else if (w_pop) begin
          w_state_next = FETCH;
        end else begin
          w_state_next = HOLD;
        end
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
    if (redirect_valid && (r_state != BOOT)) begin
      w_addr = w_redirect_addr;
    end else begin
      w_addr = r_pc;
    end
  end

  // Response capture; a redirect in the arrival cycle drops it
  always_comb begin
    w_resp_entry.pc    = r_inflight_pc;
    w_resp_entry.instr = imem_rdata;
    w_resp             = imem_rvalid && r_inflight && !redirect_valid;
    w_pop              = w_head_valid && if_ready && !redirect_valid;
  end

`ifdef IF_PREFETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_resp && (w_count == '0) && if_ready;
  assign w_push      = w_resp && !w_bypass;
  assign w_load_head = w_bypass;
  assign if_valid    = w_head_valid | w_bypass;
  assign if_pc       = w_bypass ? r_inflight_pc : w_head.pc;
  assign if_instr    = w_bypass ? imem_rdata : w_head.instr;
`else
  assign w_push      = w_resp;
  assign w_load_head = 1'b0;
  assign if_valid    = w_head_valid;
  assign if_pc       = w_head.pc;
  assign if_instr    = w_head.instr;
`endif

  assign imem_req  = w_req;
  assign imem_addr = w_addr;

  // PC, FSM state and in-flight tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (w_req) begin
        r_pc          <= w_addr + XLEN'(3'd4);
        r_inflight    <= 1'b1;
        r_inflight_pc <= w_addr;
      end else begin
        r_inflight <= 1'b0;
        if (redirect_valid) begin
          r_pc <= w_redirect_addr;
        end else begin
          r_pc <= r_pc;
        end
      end
    end
  end

  if_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .i_load_head  (w_load_head),
    .i_data       (w_resp_entry),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: behavioural 1-cycle imem plus a {pc, instr} scoreboard.
module tb_if_prefetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        spurious = 1'b0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pops = 0;
  int   cyc    = 0;
  exp_t sb[$];

`ifdef IF_PREFETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  if_prefetch_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  // Instruction memory with a fixed 1-cycle read latency
  always @(posedge clk) begin
    imem_rvalid <= imem_req | spurious;
    imem_rdata  <= instr_of(imem_addr);
  end

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = instr_of(e.pc);
      sb.push_back(e);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then score any handshake that will happen
  task automatic cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    if_ready       = rdy;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    cyc++;
    #1;
    if (if_valid && if_ready && !redirect_valid) begin
      n_pops++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, no entry expected", if_pc, if_instr);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          n_fail++;
          $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    spurious       = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_instr !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h want 00000013", if_instr); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", imem_req); end
    cycle(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    int first_req;
    int first_vld;
    int pops0;
    do_reset();
    push_stream(32'h0, 40);
    first_req = -1;
    first_vld = -1;
    pops0     = n_pops;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (imem_req && first_req < 0) first_req = cyc;
      if (if_valid && first_vld < 0) first_vld = cyc;
    end
    n_cmp++;
    if (first_vld - first_req != EXP_LAT) begin
      n_fail++; $display("FAIL stream_latency: got %0d want %0d", first_vld - first_req, EXP_LAT);
    end
    n_cmp++;
    if (n_pops - pops0 != 12 - EXP_LAT) begin
      n_fail++; $display("FAIL stream_pops: got %0d want %0d", n_pops - pops0, 12 - EXP_LAT);
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    logic [31:0] last_addr;
    logic        found;
    int          pops0;
    do_reset();
    push_stream(32'h0, 40);
    nreq      = 0;
    last_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      spurious = (i == 6);
      cycle(1'b0, 1'b0, 32'h0);
      if (imem_req) begin
        nreq++;
        last_addr = imem_addr;
      end
    end
    spurious = 1'b0;
    n_cmp++; if (nreq != 4) begin n_fail++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
    n_cmp++; if (last_addr !== 32'hC) begin n_fail++; $display("FAIL bp_last_addr: got %h want c", last_addr); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req: got %b want 0", imem_req); end
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", if_valid, if_pc);
    end
    found = 1'b0;
    pops0 = n_pops;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (imem_req && !found) begin
        found = 1'b1;
        n_cmp++;
        if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 10", imem_addr); end
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL bp_resume: got no request want one"); end
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    n_cmp++; if (n_pops - pops0 != 12) begin n_fail++; $display("FAIL bp_pops: got %0d want 12", n_pops - pops0); end
  endtask

  task automatic test_redirect();
    logic found;
    do_reset();
    push_stream(32'h0, 40);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr === 32'h8) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rd_find8: got none want req at 8"); end
    sb.delete();
    push_stream(32'h100, 40);
    cycle(1'b1, 1'b1, 32'h100);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL rd_req: got req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
    cycle(1'b1, 1'b0, 32'h0);
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_gap: got valid=%b want 0", if_valid); end
    cycle(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
      n_fail++; $display("FAIL rd_target: got valid=%b pc=%h want 1/100", if_valid, if_pc);
    end
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_full();
    do_reset();
    push_stream(32'h0, 40);
    repeat (8) cycle(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++; $display("FAIL rf_full: got req=%b valid=%b want 0/1", imem_req, if_valid);
    end
    sb.delete();
    push_stream(32'h200, 40);
    cycle(1'b1, 1'b1, 32'h203);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL rf_addr: got req=%b addr=%h want 1/200", imem_req, imem_addr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rf_empty: got valid=%b want 0", if_valid); end
    cycle(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== instr_of(32'h200)) begin
      n_fail++; $display("FAIL rf_head: got valid=%b pc=%h instr=%h want 1/200/%h",
                         if_valid, if_pc, if_instr, instr_of(32'h200));
    end
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    do_reset();
    push_stream(32'h0, 40);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got valid=%b want 1", if_valid); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL ar_async: got valid=%b req=%b want 0/0", if_valid, imem_req);
    end
    n_cmp++;
    if (imem_addr !== 32'h0 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL ar_values: got addr=%h pc=%h want 0/0", imem_addr, if_pc);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    push_stream(32'h0, 40);
    cycle(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL ar_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
  endtask

`ifdef IF_PREFETCH_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    push_stream(32'h0, 40);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_rvalid !== 1'b1 || if_valid !== 1'b1 || if_instr !== imem_rdata || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL bypass: got rvalid=%b valid=%b pc=%h instr=%h want 1/1/0/%h",
                         imem_rvalid, if_valid, if_pc, if_instr, imem_rdata);
    end
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_async_reset();
`ifdef IF_PREFETCH_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
